// File: rtl/orion_rd_pkg.sv
// Shared types and constants for the capture-memory readout path.
// Holds the FSM state encoding, the per-read tag layout and the default bank depth.
// No logic lives here.
package orion_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int HALF_DEPTH    = 176128;
    localparam int DEPTH_DEFAULT = 2 * HALF_DEPTH;

    // Travels alongside an outstanding memory read until its data returns
    typedef struct packed {
        logic valid;
        logic bank;
        logic last;
    } tag_t;

endpackage

// File: rtl/rd_fifo.sv
// Small synchronous first-word-fall-through FIFO buffering returned samples.
// Latency: a pushed word is visible on rd_data the cycle after the push.
// Backpressure: none internally; the caller's credit accounting keeps it from overflowing.
module rd_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // Storage is cleared on reset so the stream outputs start at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !flush && !do_pop && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/capture_reader.sv
// Drains bank A then bank B of the capture memory after a done pulse onto a valid/ready stream.
// Latency: word issued (ren low) in cycle N is pushed at end of N+RD_LAT; m_valid rises in N+RD_LAT+1.
// Backpressure: reads are issued only while buffered plus in-flight words leave room in the FIFO.
module capture_reader
    import orion_rd_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int ADDR_W     = 19,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              done,
    input  logic [15:0]       data_tomcu,
    input  logic              abort,
    output logic [ADDR_W-1:0] read_addr,
    output logic              ren,
    output logic              cs_mem,
    output logic [15:0]       m_data,
    output logic              m_bank,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic              done_q;
    logic              done_rise;
    logic              run_abort;
    logic              issue;
    logic              issue_last;
    logic              issue_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              bank_nxt;
    logic              pop;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W-1:0]  occ_nxt;
    tag_t              tag_sr [RD_LAT];
    tag_t              tap;
    logic [CNT_W-1:0]  fifo_count;
    logic [17:0]       fifo_rd;

    assign done_rise  = done & ~done_q;
    assign run_abort  = abort & (state != IDLE);
    assign issue      = ~ren;
    assign issue_last = issue & cs_mem & (read_addr == LAST_ADDR);
    assign pop        = m_valid & m_ready;
    // occ counts words buffered plus words requested but not yet returned
    assign occ_nxt    = occ + CNT_W'(issue) - CNT_W'(pop);
    assign tap        = tag_sr[RD_LAT-1];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: abort outranks everything outside IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (done_rise)         state_nxt = ARMED;
            ARMED: if (abort)             state_nxt = IDLE;
                   else if (!done)        state_nxt = READ;
            READ:  if (abort)             state_nxt = IDLE;
                   else if (issue_last)   state_nxt = DRAIN;
            DRAIN: if (abort)             state_nxt = IDLE;
                   else if (pop && m_last) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Decide next cycle's read and its address; read_addr holds the last issued word
    always_comb begin
        issue_nxt = (state_nxt == READ) && (occ_nxt < CNT_W'(FIFO_DEPTH));
        addr_nxt  = read_addr + ADDR_W'(1);
        bank_nxt  = cs_mem;
        if (state == ARMED) begin
            addr_nxt = '0;
            bank_nxt = 1'b0;
        end else if (read_addr == LAST_ADDR) begin
            addr_nxt = '0;
            bank_nxt = 1'b1;
        end
    end

    // Registered memory-port controls and busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ren       <= 1'b1;
            read_addr <= '0;
            cs_mem    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ren  <= ~issue_nxt;
            busy <= (state_nxt != IDLE);
            if (issue_nxt) begin
                read_addr <= addr_nxt;
                cs_mem    <= bank_nxt;
            end
        end
    end

    // Edge detect, credit counter and sticky overrun flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q  <= 1'b0;
            occ     <= '0;
            overrun <= 1'b0;
        end else begin
            done_q <= done;
            occ    <= run_abort ? '0 : occ_nxt;
            if (state == IDLE && state_nxt == ARMED)
                overrun <= 1'b0;
            else if (done_rise && !abort && (state == READ || state == DRAIN))
                overrun <= 1'b1;
        end
    end

    // Tag pipeline matching the memory read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++)
                tag_sr[i] <= '0;
        end else if (run_abort) begin
            for (int i = 0; i < RD_LAT; i++)
                tag_sr[i] <= '0;
        end else begin
            tag_sr[0] <= tag_t'{valid: issue, bank: cs_mem,
                                last: cs_mem & (read_addr == LAST_ADDR)};
            for (int i = 1; i < RD_LAT; i++)
                tag_sr[i] <= tag_sr[i-1];
        end
    end

    rd_fifo #(
        .WIDTH (18),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tap.valid),
        .pop     (pop),
        .flush   (run_abort),
        .wr_data ({data_tomcu, tap.bank, tap.last}),
        .rd_data (fifo_rd),
        .count   (fifo_count)
    );

    assign m_valid = (fifo_count != '0);
    assign m_data  = fifo_rd[17:2];
    assign m_bank  = fifo_rd[1];
    assign m_last  = fifo_rd[0];

    credit_chk: assert property (@(posedge clk) disable iff (!reset_n) fifo_count <= occ);

endmodule
